// File: rtl/wisard_pkg.sv
// Shared types and helpers for the WiSARD classifier: frame flags, score sizing, argmax rule.
// Optional training write path is enabled with the WISARD_TRAIN_EN macro.
package wisard_pkg;

    typedef struct packed {
        logic sop;
        logic eop;
        logic valid;
    } frame_flags_t;

    // Enough bits to count one hit from every RAM a frame can address.
    function automatic int score_width(input int index_width);
        return $clog2((1 << index_width) + 1);
    endfunction

    // Strictly greater only, so an earlier (lower) class keeps the lead on a tie.
    function automatic logic takes_lead(input int unsigned cand, input int unsigned best);
        return cand > best;
    endfunction

endpackage

// File: rtl/wisard_classifier_if.sv
// Frame-in / result-out bus of the WiSARD classifier; train/train_class exist only with WISARD_TRAIN_EN.
interface wisard_classifier_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int INDEX_WIDTH   = 6,
    parameter int CLASS_WIDTH   = 4
);
    logic                     sop;
    logic                     sink_valid;
    logic                     eop;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [INDEX_WIDTH-1:0]   index;
`ifdef WISARD_TRAIN_EN
    logic                     train;
    logic [CLASS_WIDTH-1:0]   train_class;
`endif
    logic                     source_valid;
    logic [CLASS_WIDTH-1:0]   class_result;

    modport master (
        output sop, sink_valid, eop, addr, index,
`ifdef WISARD_TRAIN_EN
        train, train_class,
`endif
        input  source_valid, class_result
    );

    modport slave (
        input  sop, sink_valid, eop, addr, index,
`ifdef WISARD_TRAIN_EN
        train, train_class,
`endif
        output source_valid, class_result
    );
endinterface

// File: rtl/wisard_discriminator.sv
// One class: bit-RAM with sync read, per-frame hit accumulator and final-score register (WISARD_TRAIN_EN adds writes).
// Latency: bit valid 1 cycle after the beat, score/final 2 cycles after.
// Backpressure: none; follows the flag pipeline every cycle.
module wisard_discriminator
    import wisard_pkg::*;
#(
    parameter int    ADDRESS_WIDTH = 8,
    parameter int    INDEX_WIDTH   = 6,
    parameter int    SCORE_WIDTH   = 7,
    parameter int    CLASS_ID      = 0,
    parameter string MEM_INIT_FILE = ""
) (
    input  logic                               clk,
    input  logic                               rst,
`ifdef WISARD_TRAIN_EN
    input  logic                               wr_en,
`endif
    input  logic [INDEX_WIDTH+ADDRESS_WIDTH-1:0] rd_addr,
    input  frame_flags_t                       s1_flags,
    output logic [SCORE_WIDTH-1:0]             final_score
);
    localparam int DEPTH = 1 << (INDEX_WIDTH + ADDRESS_WIDTH);

    logic                   mem [DEPTH];
    logic                   rd_bit;
    logic [SCORE_WIDTH-1:0] score;
    logic [SCORE_WIDTH-1:0] score_base;
    logic [SCORE_WIDTH-1:0] score_nxt;

    // Power-up contents only; reset never touches the RAM.
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 1'b0;
    end

    always_ff @(posedge clk) begin
`ifdef WISARD_TRAIN_EN
        if (wr_en) mem[rd_addr] <= 1'b1;
`endif
        rd_bit <= mem[rd_addr];
    end

    always_comb begin
        score_base = s1_flags.sop ? '0 : score;
        if (score_base == {SCORE_WIDTH{1'b1}}) score_nxt = score_base;
        else                                   score_nxt = score_base + SCORE_WIDTH'(rd_bit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            score       <= '0;
            final_score <= '0;
        end else if (s1_flags.valid) begin
            score <= score_nxt;
            if (s1_flags.eop) final_score <= score_nxt;
        end
    end

endmodule

// File: rtl/wisard_classifier.sv
// WiSARD inference core: per-frame class scoring and argmax; WISARD_TRAIN_EN adds a bit-set training path.
// Latency: source_valid rises 3 cycles after the eop beat.
// Backpressure: none; every sink_valid beat is accepted.
module wisard_classifier
    import wisard_pkg::*;
#(
    parameter int    ADDRESS_WIDTH = 8,
    parameter int    INDEX_WIDTH   = 6,
    parameter int    N_CLASSES     = 10,
    parameter int    CLASS_WIDTH   = 4,
    parameter string MEM_INIT_FILE = ""
) (
    input  logic               clk,
    input  logic               rst,
    wisard_classifier_if.slave bus
);
    localparam int SW     = score_width(INDEX_WIDTH);
    localparam int RAM_AW = INDEX_WIDTH + ADDRESS_WIDTH;

    logic [RAM_AW-1:0]      rd_addr;
    logic                   train_beat;
    logic                   frame_open;
    frame_flags_t           beat_flags;
    frame_flags_t           s1_flags;
    frame_flags_t           s2_flags;
    logic [SW-1:0]          final_score [N_CLASSES];
    logic [CLASS_WIDTH-1:0] best_idx;
    logic [SW-1:0]          best_score;
    logic                   result_fire;

    assign rd_addr = {bus.index, bus.addr};

`ifdef WISARD_TRAIN_EN
    logic [N_CLASSES-1:0] wr_en;

    assign train_beat = bus.train;
    always_comb begin
        wr_en = '0;
        for (int c = 0; c < N_CLASSES; c++) begin
            wr_en[c] = bus.sink_valid & bus.train & (bus.train_class == CLASS_WIDTH'(c));
        end
    end
`else
    assign train_beat = 1'b0;
`endif

    // An eop only counts inside a frame opened by sop since the last reset.
    always_comb begin
        beat_flags.valid = bus.sink_valid & ~train_beat;
        beat_flags.sop   = beat_flags.valid & bus.sop;
        beat_flags.eop   = beat_flags.valid & bus.eop & (bus.sop | frame_open);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_flags   <= '0;
            s2_flags   <= '0;
            frame_open <= 1'b0;
        end else begin
            s1_flags <= beat_flags;
            s2_flags <= s1_flags;
            if (beat_flags.sop) frame_open <= 1'b1;
        end
    end

    for (genvar c = 0; c < N_CLASSES; c++) begin : gen_disc
        wisard_discriminator #(
            .ADDRESS_WIDTH (ADDRESS_WIDTH),
            .INDEX_WIDTH   (INDEX_WIDTH),
            .SCORE_WIDTH   (SW),
            .CLASS_ID      (c),
            .MEM_INIT_FILE (MEM_INIT_FILE)
        ) u_disc (
            .clk         (clk),
            .rst         (rst),
`ifdef WISARD_TRAIN_EN
            .wr_en       (wr_en[c]),
`endif
            .rd_addr     (rd_addr),
            .s1_flags    (s1_flags),
            .final_score (final_score[c])
        );
    end

    always_comb begin
        best_idx   = '0;
        best_score = final_score[0];
        for (int c = 1; c < N_CLASSES; c++) begin
            if (takes_lead(32'(final_score[c]), 32'(best_score))) begin
                best_idx   = CLASS_WIDTH'(c);
                best_score = final_score[c];
            end
        end
    end

    assign result_fire = s2_flags.valid & s2_flags.eop;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.source_valid <= 1'b0;
            bus.class_result <= '0;
        end else begin
            bus.source_valid <= result_fire;
            if (result_fire) bus.class_result <= best_idx;
        end
    end

endmodule

// File: tb/tb_wisard_classifier.sv
// Directed bench for wisard_classifier: RAM bits are poked per class, frames driven, strobes logged and checked.
module tb_wisard_classifier;
    localparam int AW = 8;
    localparam int IW = 6;
    localparam int NC = 10;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   eop_cyc = 0;
    int   eop_a = 0;
    int   sv_cyc [$];
    int   sv_val [$];

    wisard_classifier_if #(.ADDRESS_WIDTH(AW), .INDEX_WIDTH(IW), .CLASS_WIDTH(CW)) bus ();

    wisard_classifier #(
        .ADDRESS_WIDTH (AW),
        .INDEX_WIDTH   (IW),
        .N_CLASSES     (NC),
        .CLASS_WIDTH   (CW),
        .MEM_INIT_FILE ("")
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.source_valid === 1'b1) begin
            sv_cyc.push_back(cyc);
            sv_val.push_back(int'(bus.class_result));
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_bit(input int c, input int a, input logic v);
        case (c)
            0: dut.gen_disc[0].u_disc.mem[a] = v;
            1: dut.gen_disc[1].u_disc.mem[a] = v;
            2: dut.gen_disc[2].u_disc.mem[a] = v;
            3: dut.gen_disc[3].u_disc.mem[a] = v;
            4: dut.gen_disc[4].u_disc.mem[a] = v;
            5: dut.gen_disc[5].u_disc.mem[a] = v;
            6: dut.gen_disc[6].u_disc.mem[a] = v;
            7: dut.gen_disc[7].u_disc.mem[a] = v;
            8: dut.gen_disc[8].u_disc.mem[a] = v;
            9: dut.gen_disc[9].u_disc.mem[a] = v;
            default: ;
        endcase
    endtask

    // RAM i of a pattern is addressed at base+i; set its first n bits for class c.
    task automatic set_pattern(input int c, input int base, input int n);
        for (int i = 0; i < n; i++) set_bit(c, i * 256 + base + i, 1'b1);
    endtask

    task automatic clear_pattern(input int base);
        for (int c = 0; c < NC; c++)
            for (int i = 0; i < 4; i++) set_bit(c, i * 256 + base + i, 1'b0);
    endtask

    task automatic beat(input logic s, input logic e, input int idx, input int a);
        @(negedge clk);
        bus.sink_valid = 1'b1;
        bus.sop        = s;
        bus.eop        = e;
        bus.index      = IW'(idx);
        bus.addr       = AW'(a);
        if (e) eop_cyc = cyc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.sink_valid = 1'b0;
            bus.sop        = 1'b0;
            bus.eop        = 1'b0;
            bus.addr       = AW'($urandom);
            bus.index      = IW'($urandom);
        end
    endtask

    task automatic run_frame(input int base, input int gap);
        for (int i = 0; i < 4; i++) begin
            beat(i == 0, i == 3, i, base + i);
            if (i == 1 && gap > 0) idle(gap);
        end
    endtask

    task automatic expect_one(input string tag, input int exp_val, input int exp_cyc);
        check({tag, "_count"}, sv_cyc.size(), 1);
        if (sv_cyc.size() > 0) begin
            check({tag, "_class"}, sv_val[0], exp_val);
            check({tag, "_cycle"}, sv_cyc[0], exp_cyc);
        end
        sv_cyc.delete();
        sv_val.delete();
    endtask

    initial begin
        bus.sink_valid = 1'b0;
        bus.sop        = 1'b0;
        bus.eop        = 1'b0;
        bus.addr       = '0;
        bus.index      = '0;
`ifdef WISARD_TRAIN_EN
        bus.train       = 1'b0;
        bus.train_class = '0;
`endif
        idle(3);
        check("reset_source_valid", bus.source_valid, 0);
        check("reset_class_result", bus.class_result, 0);
        rst = 1'b0;
        idle(2);

        // Class 3 hits all 4 RAMs, every other class hits only RAM 0.
        set_pattern(3, 8'h10, 4);
        for (int c = 0; c < NC; c++) if (c != 3) set_pattern(c, 8'h10, 1);
        run_frame(8'h10, 0);
        idle(1);
        check("t1_no_early_strobe", sv_cyc.size(), 0);
        idle(6);
        expect_one("t1", 3, eop_cyc + 3);
        check("t1_result_held", bus.class_result, 3);

        // Same frame with a 3-cycle sink_valid gap after beat 2.
        run_frame(8'h10, 3);
        idle(7);
        expect_one("t4_gap", 3, eop_cyc + 3);
        clear_pattern(8'h10);

        // Tie between classes 2 and 5 at 4 hits.
        set_pattern(2, 8'h20, 4);
        set_pattern(5, 8'h20, 4);
        set_pattern(8, 8'h20, 3);
        set_pattern(0, 8'h20, 2);
        run_frame(8'h20, 0);
        idle(7);
        expect_one("t2_tie", 2, eop_cyc + 3);
        clear_pattern(8'h20);

        // Back-to-back frames A then B with no idle cycle.
        set_pattern(7, 8'h30, 4);
        set_pattern(1, 8'h30, 1);
        set_pattern(1, 8'h40, 4);
        set_pattern(7, 8'h40, 2);
        run_frame(8'h30, 0);
        eop_a = eop_cyc;
        run_frame(8'h40, 0);
        idle(8);
        check("t3_count", sv_cyc.size(), 2);
        if (sv_cyc.size() == 2) begin
            check("t3_a_class", sv_val[0], 7);
            check("t3_a_cycle", sv_cyc[0], eop_a + 3);
            check("t3_b_class", sv_val[1], 1);
            check("t3_b_spacing", sv_cyc[1] - sv_cyc[0], 4);
        end
        sv_cyc.delete();
        sv_val.delete();
        clear_pattern(8'h30);
        clear_pattern(8'h40);

        // Reset pulse on beat 2 drops the frame; the tail without sop must not strobe.
        set_pattern(6, 8'h50, 4);
        beat(1'b1, 1'b0, 0, 8'h50);
        beat(1'b0, 1'b0, 1, 8'h51);
        rst = 1'b1;
        beat(1'b0, 1'b0, 2, 8'h52);
        rst = 1'b0;
        beat(1'b0, 1'b1, 3, 8'h53);
        idle(7);
        check("t5_dropped_count", sv_cyc.size(), 0);
        check("t5_result_cleared", bus.class_result, 0);
        sv_cyc.delete();
        sv_val.delete();
        run_frame(8'h50, 0);
        idle(7);
        expect_one("t5_clean", 6, eop_cyc + 3);
        clear_pattern(8'h50);

        // One-RAM frame: sop and eop on the same beat.
        set_bit(9, 8'h60, 1'b1);
        beat(1'b1, 1'b1, 0, 8'h60);
        idle(7);
        expect_one("t6_single", 9, eop_cyc + 3);
        set_bit(9, 8'h60, 1'b0);

        // No bit set anywhere: all scores zero, class 0 wins.
        run_frame(8'h70, 0);
        idle(7);
        expect_one("t7_all_zero", 0, eop_cyc + 3);

`ifdef WISARD_TRAIN_EN
        // Train class 4 on pattern 0x80, then classify it.
        for (int i = 0; i < 4; i++) begin
            beat(1'b0, 1'b0, i, 8'h80 + i);
            bus.train       = 1'b1;
            bus.train_class = CW'(4);
        end
        @(negedge clk);
        bus.train      = 1'b0;
        bus.sink_valid = 1'b0;
        idle(5);
        check("t8_train_no_strobe", sv_cyc.size(), 0);
        run_frame(8'h80, 0);
        idle(7);
        expect_one("t8_trained", 4, eop_cyc + 3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
